// File: rtl/audio_buf_arbiter.sv
// Three-port arbiter for the single-port audio buffer SRAM. Port 0 has fixed priority with a
// starvation guard, ports 1/2 are round-robin, and a run/drain/halt controller quiesces it. Optional counters: AUDIO_BUF_ARB_STATS_EN.
module audio_buf_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  idle,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [31:0]           debug_status
);

    typedef enum logic [1:0] {
        HALT  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] port;
    } tag_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          rr_ptr;
    logic [7:0]          starve_cnt;
    tag_t                tag_s1;
    tag_t                tag_s2;
    logic                pipe_empty;
    logic                hi_req;
    logic                accept;
    logic                acc_we;
    logic [1:0]          acc_port;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [19:0]         stats;

    assign hi_req     = req[1] | req[2];
    assign pipe_empty = !tag_s1.valid && !tag_s2.valid;
    assign idle       = (state == HALT);

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            HALT:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN:   if (pipe_empty) state_nxt = enable ? RUN : HALT;
            default: state_nxt = HALT;
        endcase
    end

    // Grants are withheld in the very cycle enable drops, so draining starts with no new accepts.
    always_comb begin
        gnt = 3'b000;
        if (state == RUN && enable) begin
            if (req[0] && !(starve_cnt == STARVE_LIM && hi_req)) begin
                gnt = 3'b001;
            end else if (req[1] && req[2]) begin
                gnt = (rr_ptr == 2'd1) ? 3'b010 : 3'b100;
            end else if (req[1]) begin
                gnt = 3'b010;
            end else if (req[2]) begin
                gnt = 3'b100;
            end
        end
    end

    always_comb begin
        acc_port  = 2'd0;
        acc_addr  = addr[0 +: ADDR_W];
        acc_wdata = wdata[0 +: DATA_W];
        if (gnt[1]) begin
            acc_port  = 2'd1;
            acc_addr  = addr[ADDR_W +: ADDR_W];
            acc_wdata = wdata[DATA_W +: DATA_W];
        end else if (gnt[2]) begin
            acc_port  = 2'd2;
            acc_addr  = addr[2*ADDR_W +: ADDR_W];
            acc_wdata = wdata[2*DATA_W +: DATA_W];
        end
    end

    assign accept = |(req & gnt);
    assign acc_we = |(we & gnt);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HALT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= 2'd1;
            starve_cnt <= 8'd0;
        end else begin
            if (gnt[1]) begin
                rr_ptr <= 2'd2;
            end else if (gnt[2]) begin
                rr_ptr <= 2'd1;
            end

            if (gnt[0] && hi_req) begin
                if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 8'd1;
            end else if (gnt[1] || gnt[2] || !hi_req) begin
                starve_cnt <= 8'd0;
            end
        end
    end

    // Address and write data hold between commands; only the strobes pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
        end else begin
            mem_wen <= accept && acc_we;
            mem_ren <= accept && !acc_we;
            if (accept) begin
                mem_addr  <= acc_addr;
                mem_wdata <= acc_wdata;
            end
        end
    end

    // Tag stage 1 lines up with mem_ren, stage 2 with mem_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_s1 <= '0;
            tag_s2 <= '0;
            rvalid <= 3'b000;
            rdata  <= '0;
        end else begin
            tag_s1.valid <= accept && !acc_we;
            tag_s1.port  <= acc_port;
            tag_s2       <= tag_s1;
            rvalid       <= tag_s2.valid ? (3'b001 << tag_s2.port) : 3'b000;
            if (tag_s2.valid) rdata <= mem_rdata;
        end
    end

`ifdef AUDIO_BUF_ARB_STATS_EN
    logic [7:0] conflict_cnt;
    logic [5:0] rd_cnt;
    logic [5:0] wr_cnt;
    logic       multi_req;

    assign multi_req = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= 8'd0;
            rd_cnt       <= 6'd0;
            wr_cnt       <= 6'd0;
        end else begin
            if (state == RUN && multi_req && conflict_cnt != 8'hFF) conflict_cnt <= conflict_cnt + 8'd1;
            if (accept && !acc_we && rd_cnt != 6'h3F) rd_cnt <= rd_cnt + 6'd1;
            if (accept && acc_we && wr_cnt != 6'h3F) wr_cnt <= wr_cnt + 6'd1;
        end
    end

    assign stats = {conflict_cnt, rd_cnt, wr_cnt};
`else
    assign stats = 20'd0;
`endif

    assign debug_status = {state, rr_ptr, starve_cnt, stats};

endmodule

// File: doc/audio_buf_arbiter.md
Name: audio_buf_arbiter

Overview:
- Arbitrates the single-port audio buffer SRAM between three requesters:
  - port 0: PCM ingest writer
  - port 1: pre-emphasis/windowing engine
  - port 2: time-domain output streamer
- Port 0 has fixed priority, with a starvation guard. Ports 1 and 2 are served round-robin.
- Registers the SRAM command and returns read data, tagged to the requester that issued the read.
- Includes a run/drain/halt controller so firmware can quiesce the buffer before a frame reconfiguration.

Parameters:
- ADDR_W, 12, SRAM address width
- DATA_W, 32, SRAM data width
- STARVE_MAX, 8, maximum consecutive port-0 grants while port 1 or port 2 is pending (range 1..255)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  1 = run; 0 = drain, then halt
- idle  out  1  high in HALT state
- req  in  3  per-port request, bit i = port i
- we  in  3  per-port write (1) / read (0)
- addr  in  3*ADDR_W  port i at [i*ADDR_W +: ADDR_W]
- wdata  in  3*DATA_W  port i at [i*DATA_W +: DATA_W]
- gnt  out  3  combinational one-hot grant
- rvalid  out  3  one-cycle read-return pulse per port
- rdata  out  DATA_W  read data, shared by all ports, qualified by rvalid
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_wen  out  1  SRAM write enable
- mem_ren  out  1  SRAM read enable
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after mem_ren
- debug_status  out  32  status word

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values:
  - state = HALT, idle = 1.
  - gnt, rvalid, mem_wen, mem_ren = 0.
  - rdata, mem_addr, mem_wdata = 0.
  - rr_ptr = port 1; starve_cnt = 0; in-flight pipeline tags cleared.
  - A reset asserted mid-operation discards in-flight reads: no rvalid is produced for them.
- Requester rule: req, we, addr and wdata are held stable until the cycle gnt[i] = 1. A transfer is accepted when req[i] & gnt[i].
- Grant logic (combinational):
  - gnt = 0 unless state = RUN. At most one bit is set.
  - Port 0 wins if req[0] and NOT (starve_cnt == STARVE_MAX and (req[1] | req[2])).
  - Otherwise, if exactly one of req[1], req[2] is set, that port wins.
  - If both req[1] and req[2] are set, the port named by rr_ptr wins.
- rr_ptr: on a grant to port 1 or port 2, rr_ptr moves to the other port.
- starve_cnt (8-bit):
  - Increments on a port-0 grant while req[1] | req[2].
  - Clears on any port-1/2 grant, or when req[1:2] are both 0.
  - Saturates at STARVE_MAX.
- Command timing (accept in cycle T):
  - Cycle T+1: mem_addr, mem_wdata, and mem_wen (if we) or mem_ren (if read) are registered, one-cycle pulse.
  - If no transfer is accepted in cycle T, mem_wen = mem_ren = 0 in T+1; mem_addr and mem_wdata hold their values.
  - Reads: mem_rdata is valid in T+2. rdata <= mem_rdata and rvalid[i] <= 1 are registered at the end of T+2, so they are visible in T+3.
  - Read latency is 3 cycles from accept. Writes produce no response.
  - Throughput: 1 access per cycle; back-to-back accepts from any mix of ports.
- Tag pipeline: two stages, each {valid, port[1:0]} for reads. pipe_empty = both stages invalid.
- State machine:
  - HALT: idle = 1. Goes to RUN next cycle if enable = 1.
  - RUN: grants active. Goes to DRAIN if enable = 0; no grant is issued in the cycle enable is seen low.
  - DRAIN: no grants. When pipe_empty, goes to RUN if enable = 1, else HALT. In-flight reads complete normally.
- Simultaneous events: the accept in cycle T and the rvalid for an earlier read may coincide; both proceed independently.
- debug_status:
  - [31:30] state: 00 HALT, 01 RUN, 10 DRAIN
  - [29:28] rr_ptr
  - [27:20] starve_cnt
  - [19:0] per the optional feature

Optional Feature:
- Macro: AUDIO_BUF_ARB_STATS_EN.
- Defined:
  - debug_status[19:0] = {conflict_cnt[7:0], rd_cnt[5:0], wr_cnt[5:0]}. All counters are saturating and cleared by rst.
  - conflict_cnt counts cycles with ≥2 req bits set in RUN.
  - rd_cnt and wr_cnt count accepted reads and writes.
- Undefined: debug_status[19:0] = 0, and no counter flops are present.

Test Plan:
- Reset, then enable = 1: idle = 1 → 0 after 1 cycle. Single read by port 1 at addr 0x010, SRAM returns 0xDEADBEEF → mem_ren pulse at T+1 with mem_addr = 0x010; rvalid = 3'b010 and rdata = 0xDEADBEEF at T+3.
- req = 3'b110 held for 4 cycles → gnt sequence 010, 100, 010, 100.
- req = 3'b011 held, STARVE_MAX = 8 → gnt[0] for 8 cycles, then gnt[1] for 1 cycle, then gnt[0] again; starve_cnt in debug_status[27:20] reads 8, then 0.
- Port-2 read accepted; enable dropped the next cycle → no further gnt; rvalid[2] still pulses; state passes through DRAIN, then HALT with idle = 1; re-enable → RUN after 1 cycle.
- Port-0 write of 0x00123456 to 0x000 and port-1 read of 0x005 on back-to-back cycles → mem_wen then mem_ren on consecutive cycles with the correct addresses. rst asserted in the cycle after mem_ren → no rvalid; all outputs return to reset values.
- With AUDIO_BUF_ARB_STATS_EN: 3 writes, 2 reads and 4 conflict cycles → debug_status[19:0] = {8'd4, 6'd2, 6'd3}. Without the macro → debug_status[19:0] = 0.
